// File: rtl/keypad_digit_entry.sv
// Debounced one-hot keypad front end: one BCD event per press, digits shifted into a time-entry buffer.
// Event and buffer update land on the edge that completes debounce; multi-key samples never produce events.
module keypad_digit_entry #(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enablen,
  input  logic [NUM_KEYS-1:0]               teclado,
  input  logic                              clear_digits,
  output logic [3:0]                        key_code,
  output logic                              key_valid,
  output logic                              multi_key,
  output logic                              overflow,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              full
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DCW = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [3:0]              cand_q, cand_d;
  logic [3:0]              key_code_q, key_code_d;
  logic                    key_valid_q, key_valid_d;
  logic                    multi_key_q, multi_key_d;
  logic                    overflow_q, overflow_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [DCW-1:0]          digit_count_q, digit_count_d;

  logic [4:0]              n_set;
  logic [3:0]              key_idx;
  logic                    is_none, is_one, is_multi;
  logic                    accept;
  logic                    full_w;

  // Classify the sample: population count plus index of the (single) set line.
  always_comb begin
    n_set   = '0;
    key_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (teclado[i]) begin
        n_set   = n_set + 5'd1;
        key_idx = 4'(i);
      end
    end
  end

  assign is_none  = (n_set == 5'd0);
  assign is_one   = (n_set == 5'd1);
  assign is_multi = (n_set >= 5'd2);
  assign cnt_inc  = cnt_q + CW'(1);
  assign full_w   = (digit_count_q == DCW'(NUM_DIGITS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_one) begin
            cand_d = key_idx;
            if (DEBOUNCE_CYCLES == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!is_one || key_idx != cand_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
            accept  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          // Counter now tracks consecutive all-released samples.
          if (is_none) begin
            if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid_d   = accept;
    key_code_d    = accept ? cand_d : key_code_q;
    multi_key_d   = is_multi;
    overflow_d    = 1'b0;
    digits_d      = digits_q;
    digit_count_d = digit_count_q;
    // A clear on the accept edge wins over storing the digit.
    if (clear_digits) begin
      digits_d      = '0;
      digit_count_d = '0;
    end else if (accept) begin
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        digits_d      = digits_q << 4;
        digits_d[3:0] = cand_d;
        digit_count_d = digit_count_q + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      multi_key_q   <= 1'b0;
      overflow_q    <= 1'b0;
      digits_q      <= '0;
      digit_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      multi_key_q   <= multi_key_d;
      overflow_q    <= overflow_d;
      digits_q      <= digits_d;
      digit_count_q <= digit_count_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign multi_key   = multi_key_q;
  assign overflow    = overflow_q;
  assign digits      = digits_q;
  assign digit_count = digit_count_q;
  assign full        = full_w;

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
Clocked, parametrised successor of the combinational keypad encoder for the microwave front end. Debounces a one-hot keypad and rejects multi-key presses. Emits one BCD key event per physical press and shifts accepted digits into a time-entry buffer that the timer loader reads. Sits between the raw keypad inputs and the microwave control FSM / timer.

Parameters:
NUM_KEYS, 10, number of keypad lines; key i encodes to code i; legal range 2..16
DEBOUNCE_CYCLES, 4, consecutive identical samples required for press and for release; legal minimum 1
NUM_DIGITS, 4, depth of digit buffer in BCD nibbles (4 = mm:ss)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
enablen  in  1  active-low enable; high forces FSM to IDLE and suppresses events
teclado  in  NUM_KEYS  raw keypad lines, bit i = key i pressed
clear_digits  in  1  synchronous clear of digit buffer
key_code  out  4  code of last accepted key
key_valid  out  1  one-cycle pulse per accepted press
multi_key  out  1  registered; high while ≥2 keypad lines are sampled high
overflow  out  1  one-cycle pulse: accepted key dropped because buffer full
digits  out  4*NUM_DIGITS  buffer; newest digit in [3:0], oldest in top nibble
digit_count  out  $clog2(NUM_DIGITS+1)  number of valid digits
full  out  1  digit_count == NUM_DIGITS

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset: FSM=IDLE, debounce counter=0. key_code, key_valid, multi_key, overflow, digits, digit_count and full are all 0. Reset has priority over every other input and aborts any press in progress.
- Sample classes on each edge: NONE (all 0), ONE (exactly one bit set), MULTI (≥2 bits). multi_key <= (class==MULTI), independent of FSM state and of enablen.
- FSM states:
  - IDLE: on ONE, capture the index into cand, cnt<=1, go to DEBOUNCE. If DEBOUNCE_CYCLES==1, accept immediately and go to HELD.
  - DEBOUNCE: if the sample is not ONE with the same index, go to IDLE (no event). Else cnt++. When cnt reaches DEBOUNCE_CYCLES, accept and go to HELD.
  - HELD: waits for release. Each NONE sample increments the release counter; any non-NONE sample zeroes it. After DEBOUNCE_CYCLES consecutive NONE samples, go to IDLE. MULTI or a different key in HELD never produces an event.
- Accept, performed at the edge that completes debounce:
  - key_code <= cand; key_valid <= 1 for exactly one cycle.
  - If not full: digits <= {digits[4*NUM_DIGITS-5:0], cand}; digit_count++.
  - If full: buffer unchanged; overflow <= 1 for one cycle.
- Latency: key stable before sampling edges 1..DEBOUNCE_CYCLES gives key_valid high in the cycle after edge DEBOUNCE_CYCLES. The buffer updates on that same edge.
- Holding a key produces one event only; no auto-repeat.
- enablen=1: FSM goes to IDLE and counters clear next edge; key_valid and overflow stay 0; digits hold; clear_digits still works.
- clear_digits on the accept edge: the clear wins. digits=0 and count=0, the key is not stored, key_valid still pulses, overflow stays 0.
- clear_digits when the buffer is already empty: no effect.
- Codes are 0..NUM_KEYS-1 zero-extended to 4 bits.
- full is derived from the registered digit_count (no extra latency).

Test Plan:
1. Reset, then teclado=10'b0000100000 held 4 cycles → key_valid one pulse after edge 4, key_code=4'd5, digits=16'h0005, digit_count=1.
2. Key 3 glitches 2 cycles, then key 7 held 6 cycles, with DEBOUNCE_CYCLES=4 → a single event with key_code=7; no event for key 3.
3. teclado=10'b0000000110 held 10 cycles → multi_key=1 from the cycle after the first edge; key_valid never pulses.
4. Enter keys 1,2,3,4, each with full press and release → digits=16'h1234, full=1. A fifth key 9 → key_valid pulse, key_code=9, overflow pulse, digits stays 16'h1234.
5. Key 8 held 50 cycles, release bounces (2 NONE, 1 high, 4 NONE), then key 8 pressed again → exactly 2 events total.
6. With count=2, assert clear_digits on the accept edge of key 6 → digits=0, count=0, key_valid=1, overflow=0. Reset mid-DEBOUNCE → no event and all outputs 0.
